// File: rtl/ht_pkg.sv
// ht_pkg -- definitions shared by the horizontal and vertical Hadamard stages
// of the SATD datapath.
//   size_e      : block size code carried on size_i / out_size
//   in_state_e  : input buffer state (collecting rows / block complete)
//   out_state_e : output buffer state (nothing held / draining rows)
//   clog2()     : ceiling log2, usable in parameter expressions
//   size_to_n() : size code -> block dimension, clamped to the instance maximum
//   n_to_code() : block dimension -> size code
//   had_sign()  : sign of Sylvester Hadamard entry H[k][j] (1 = negative)
package ht_pkg;

  typedef enum logic [1:0] {
    SZ_4   = 2'd0,
    SZ_8   = 2'd1,
    SZ_16  = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  typedef enum logic {
    IN_FILL,
    IN_FULL
  } in_state_e;

  typedef enum logic {
    OUT_EMPTY,
    OUT_DRAIN
  } out_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Reserved code and any size beyond what the instance can hold fall back to
  // the largest supported block.
  function automatic int size_to_n(input logic [1:0] code, input int max_n);
    int n;
    case (size_e'(code))
      SZ_4:    n = 4;
      SZ_8:    n = 8;
      SZ_16:   n = 16;
      default: n = max_n;
    endcase
    if (n > max_n) n = max_n;
    return n;
  endfunction

  function automatic logic [1:0] n_to_code(input int n);
    logic [1:0] c;
    case (n)
      4:       c = SZ_4;
      8:       c = SZ_8;
      default: c = SZ_16;
    endcase
    return c;
  endfunction

  // Sylvester ordering: H[k][j] = (-1)^popcount(k & j).
  function automatic logic had_sign(input int k, input int j);
    return ^(k & j);
  endfunction

endpackage

// File: rtl/ht_butterfly_col.sv
// ht_butterfly_col -- combinational MAX_N-point Sylvester-order Hadamard
// butterfly over one column.
//   col_i : MAX_N packed signed lanes of W bits, lane j at [j*W +: W]
//   col_o : transformed lanes, lane k = sum_j (-1)^popcount(k&j) * lane j
// W must already include the log2(MAX_N) bits of growth; no overflow handling.
module ht_butterfly_col
  import ht_pkg::*;
#(
  parameter int MAX_N = 8,
  parameter int W     = 15
) (
  input  logic [MAX_N*W-1:0] col_i,
  output logic [MAX_N*W-1:0] col_o
);

  localparam int LOGN = clog2(MAX_N);

  // In-place radix-2 stages: at stage s the pair (i, i + 2^s) with bit s of
  // i clear becomes (a + b, a - b), which yields natural Sylvester order.
  always_comb begin
    logic signed [W-1:0] cur [MAX_N];
    logic signed [W-1:0] nxt [MAX_N];
    for (int j = 0; j < MAX_N; j++) begin
      cur[j] = col_i[j*W +: W];
      nxt[j] = '0;
    end
    for (int s = 0; s < LOGN; s++) begin
      for (int i = 0; i < MAX_N; i++) begin
        if (((i >> s) & 1) == 0) nxt[i] = cur[i] + cur[i + (1 << s)];
        else                     nxt[i] = cur[i - (1 << s)] - cur[i];
      end
      for (int i = 0; i < MAX_N; i++) cur[i] = nxt[i];
    end
    col_o = '0;
    for (int k = 0; k < MAX_N; k++) col_o[k*W +: W] = cur[k];
  end

endmodule

// File: rtl/ht_vertical_stream.sv
// ht_vertical_stream -- streaming vertical Hadamard stage of the SATD path.
// Collects an N x N block of horizontally transformed rows, transforms every
// column with the N-point Sylvester Hadamard in full precision, and drains the
// result one row per beat. N = 4/8/16 is chosen per block on its first row.
//   clk, rst_n           : clock, asynchronous active-low reset
//   size_i               : size code, sampled with row 0 of a block
//   in_valid / in_ready  : input row handshake
//   in_row               : MAX_N signed IN_W lanes, lane j at [j*IN_W +: IN_W]
//   out_valid / out_ready: output row handshake
//   out_row              : MAX_N signed OUT_W lanes, zero while out_valid=0
//   out_last             : marks row N-1 of the block being drained
//   out_size             : effective size code of the block being drained
module ht_vertical_stream
  import ht_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int MAX_N = 8,
  parameter int OUT_W = IN_W + $clog2(MAX_N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             size_i,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAX_N*IN_W-1:0]  in_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MAX_N*OUT_W-1:0] out_row,
  output logic                   out_last,
  output logic [1:0]             out_size
);

  localparam int CW = clog2(MAX_N);

  in_state_e        in_state_q, in_state_d;
  logic [CW-1:0]    in_cnt_q, in_cnt_d;
  logic [CW-1:0]    in_nm1_q, in_nm1_d;
  logic [1:0]       in_code_q, in_code_d;
  out_state_e       out_state_q, out_state_d;
  logic [CW-1:0]    out_cnt_q, out_cnt_d;
  logic [CW-1:0]    out_nm1_q, out_nm1_d;
  logic [1:0]       out_code_q, out_code_d;

  logic [MAX_N*IN_W-1:0]  in_buf_q  [MAX_N];
  logic [MAX_N*OUT_W-1:0] out_buf_q [MAX_N];

  logic [CW-1:0]          row0_nm1;
  logic [1:0]             row0_code;
  logic [CW-1:0]          cur_nm1;
  logic [MAX_N*IN_W-1:0]  in_row_m;
  logic                   in_fire, out_fire, last_pop, xfer;
  logic [MAX_N*OUT_W-1:0] col_in  [MAX_N];
  logic [MAX_N*OUT_W-1:0] col_out [MAX_N];
  logic [MAX_N*OUT_W-1:0] ht_rows [MAX_N];

  assign row0_nm1  = CW'(size_to_n(size_i, MAX_N) - 1);
  assign row0_code = n_to_code(size_to_n(size_i, MAX_N));
  // Row 0 decides the block size, so its own lane mask must come straight
  // from size_i rather than from the not-yet-updated register.
  assign cur_nm1   = (in_cnt_q == '0) ? row0_nm1 : in_nm1_q;

  assign in_ready  = (in_state_q == IN_FILL);
  assign out_valid = (out_state_q == OUT_DRAIN);
  assign out_last  = out_valid && (out_cnt_q == out_nm1_q);
  assign out_row   = out_valid ? out_buf_q[out_cnt_q] : '0;
  assign out_size  = out_code_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_pop = out_fire && (out_cnt_q == out_nm1_q);
  // Handing over on the last-pop edge keeps back-to-back blocks bubble-free.
  assign xfer     = (in_state_q == IN_FULL) && ((out_state_q == OUT_EMPTY) || last_pop);

  always_comb begin
    in_row_m = '0;
    for (int j = 0; j < MAX_N; j++) begin
      if (j <= int'(cur_nm1)) in_row_m[j*IN_W +: IN_W] = in_row[j*IN_W +: IN_W];
    end
  end

  always_comb begin
    in_state_d  = in_state_q;
    in_cnt_d    = in_cnt_q;
    in_nm1_d    = in_nm1_q;
    in_code_d   = in_code_q;
    out_state_d = out_state_q;
    out_cnt_d   = out_cnt_q;
    out_nm1_d   = out_nm1_q;
    out_code_d  = out_code_q;

    if (in_fire) begin
      if (in_cnt_q == '0) begin
        in_nm1_d  = row0_nm1;
        in_code_d = row0_code;
      end
      if (in_cnt_q == cur_nm1) begin
        in_state_d = IN_FULL;
        in_cnt_d   = '0;
      end else begin
        in_cnt_d = in_cnt_q + CW'(1);
      end
    end

    if (out_fire) begin
      if (last_pop) begin
        out_state_d = OUT_EMPTY;
        out_cnt_d   = '0;
      end else begin
        out_cnt_d = out_cnt_q + CW'(1);
      end
    end

    if (xfer) begin
      in_state_d  = IN_FILL;
      in_cnt_d    = '0;
      out_state_d = OUT_DRAIN;
      out_cnt_d   = '0;
      out_nm1_d   = in_nm1_q;
      out_code_d  = in_code_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q  <= IN_FILL;
      in_cnt_q    <= '0;
      in_nm1_q    <= '0;
      in_code_q   <= '0;
      out_state_q <= OUT_EMPTY;
      out_cnt_q   <= '0;
      out_nm1_q   <= '0;
      out_code_q  <= '0;
    end else begin
      in_state_q  <= in_state_d;
      in_cnt_q    <= in_cnt_d;
      in_nm1_q    <= in_nm1_d;
      in_code_q   <= in_code_d;
      out_state_q <= out_state_d;
      out_cnt_q   <= out_cnt_d;
      out_nm1_q   <= out_nm1_d;
      out_code_q  <= out_code_d;
    end
  end

  // Buffer contents are only meaningful under the state registers above.
  always_ff @(posedge clk) begin
    if (in_fire) in_buf_q[in_cnt_q] <= in_row_m;
    if (xfer) begin
      for (int k = 0; k < MAX_N; k++) out_buf_q[k] <= ht_rows[k];
    end
  end

  // Column gather: rows beyond N read as zero; widen before the butterfly.
  always_comb begin
    logic [IN_W-1:0] lane;
    lane = '0;
    for (int c = 0; c < MAX_N; c++) col_in[c] = '0;
    for (int c = 0; c < MAX_N; c++) begin
      for (int j = 0; j < MAX_N; j++) begin
        if (j <= int'(in_nm1_q)) begin
          lane = in_buf_q[j][c*IN_W +: IN_W];
          col_in[c][j*OUT_W +: OUT_W] = {{(OUT_W-IN_W){lane[IN_W-1]}}, lane};
        end
      end
    end
  end

  for (genvar c = 0; c < MAX_N; c++) begin : g_col
    ht_butterfly_col #(
      .MAX_N (MAX_N),
      .W     (OUT_W)
    ) u_col (
      .col_i (col_in[c]),
      .col_o (col_out[c])
    );
  end

  // The MAX_N-point result repeats the N-point rows above N, so those rows
  // are forced to zero explicitly.
  always_comb begin
    for (int k = 0; k < MAX_N; k++) ht_rows[k] = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k <= int'(in_nm1_q)) begin
        for (int c = 0; c < MAX_N; c++) begin
          ht_rows[k][c*OUT_W +: OUT_W] = col_out[c][k*OUT_W +: OUT_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_ht_vertical_stream.sv
// tb_ht_vertical_stream -- directed bench for ht_vertical_stream with
// IN_W=12, MAX_N=8 (OUT_W=15). Expected rows are hand-derived constants.
module tb_ht_vertical_stream;

  localparam int IN_W  = 12;
  localparam int MAX_N = 8;
  localparam int OUT_W = 15;
  localparam int RW    = MAX_N * IN_W;
  localparam int OW    = MAX_N * OUT_W;

  logic          clk;
  logic          rst_n;
  logic [1:0]    size_i;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_row;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_row;
  logic          out_last;
  logic [1:0]    out_size;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] blk      [MAX_N];
  logic [OW-1:0] exp_rows [MAX_N];

  ht_vertical_stream #(
    .IN_W  (IN_W),
    .MAX_N (MAX_N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .size_i    (size_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last),
    .out_size  (out_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] in_fill(input int v, input int nl);
    logic [RW-1:0] r;
    r = '0;
    for (int j = 0; j < nl; j++) r[j*IN_W +: IN_W] = IN_W'(v);
    return r;
  endfunction

  function automatic logic [OW-1:0] out_fill(input int v, input int nl);
    logic [OW-1:0] r;
    r = '0;
    for (int j = 0; j < nl; j++) r[j*OUT_W +: OUT_W] = OUT_W'(v);
    return r;
  endfunction

  task automatic clear_tables();
    for (int r = 0; r < MAX_N; r++) begin
      blk[r]      = '0;
      exp_rows[r] = '0;
    end
  endtask

  // Drives blk[0..n-1]; with toggle set, size_i flips on every later row.
  task automatic feed(input int n, input logic [1:0] sz0, input logic toggle, input string tag);
    for (int r = 0; r < n; r++) begin
      in_valid = 1'b1;
      in_row   = blk[r];
      if (r == 0)      size_i = sz0;
      else if (toggle) size_i = (r % 2 == 1) ? 2'd0 : 2'd2;
      else             size_i = sz0;
      chk($sformatf("%s_rdy%0d", tag, r), in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    in_row   = '0;
    chk($sformatf("%s_full", tag), in_ready, 1'b0);
    chk($sformatf("%s_novld", tag), out_valid, 1'b0);
  endtask

  task automatic drain(input int n, input logic chk_sz, input logic [1:0] sz, input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_vld%0d", tag, k), out_valid, 1'b1);
      chk($sformatf("%s_row%0d", tag, k), out_row, exp_rows[k]);
      chk($sformatf("%s_last%0d", tag, k), out_last, (k == n - 1));
      if (chk_sz) chk($sformatf("%s_size%0d", tag, k), out_size, sz);
      tick();
    end
    chk($sformatf("%s_end_vld", tag), out_valid, 1'b0);
    chk($sformatf("%s_end_row", tag), out_row, '0);
    chk($sformatf("%s_end_last", tag), out_last, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    size_i    = 2'd0;
    in_valid  = 1'b0;
    in_row    = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_row", out_row, '0);
    chk("rst_out_size", out_size, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // N=4, every lane +1 (lanes 4..7 driven too and must be ignored)
    clear_tables();
    for (int r = 0; r < 4; r++) blk[r] = in_fill(1, 8);
    exp_rows[0] = out_fill(4, 4);
    feed(4, 2'd0, 1'b0, "A");
    tick();
    chk("A_rdy_after_xfer", in_ready, 1'b1);
    drain(4, 1'b1, 2'd0, "A");

    // N=8 via clamped code 2 (16 > MAX_N), impulse at in[0][0]
    clear_tables();
    blk[0] = in_fill(1, 1);
    for (int k = 0; k < 8; k++) exp_rows[k] = out_fill(1, 1);
    feed(8, 2'd2, 1'b0, "B");
    tick();
    drain(8, 1'b0, 2'd0, "B");

    // N=8 via reserved code 3, every lane at the negative limit
    clear_tables();
    for (int r = 0; r < 8; r++) blk[r] = in_fill(-2048, 8);
    exp_rows[0] = out_fill(-16384, 8);
    feed(8, 2'd3, 1'b0, "C");
    tick();
    drain(8, 1'b0, 2'd0, "C");

    // Back-to-back N=4 blocks, no backpressure: block 1 all +1, block 2 all +2
    in_valid  = 1'b1;
    size_i    = 2'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_row = (i < 5) ? in_fill(1, 8) : in_fill(2, 4);
      if (i >= 9) in_valid = 1'b0;
      chk($sformatf("D_rdy%0d", i), in_ready, !(i == 4 || i == 9));
      chk($sformatf("D_vld%0d", i), out_valid, ((i >= 5 && i <= 8) || (i >= 10 && i <= 13)));
      chk($sformatf("D_row%0d", i), out_row,
          (i == 5) ? out_fill(4, 4) : ((i == 10) ? out_fill(8, 4) : '0));
      chk($sformatf("D_last%0d", i), out_last, (i == 8 || i == 13));
      tick();
    end
    in_valid = 1'b0;
    in_row   = '0;

    // Backpressure: hold out_ready low for 20 cycles while the next block fills
    clear_tables();
    for (int r = 0; r < 4; r++) blk[r] = in_fill(1, 4);
    feed(4, 2'd0, 1'b0, "E");
    out_ready = 1'b0;
    tick();
    size_i = 2'd0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 4);
      in_row   = in_fill(3, 4);
      chk($sformatf("E_hold_vld%0d", i), out_valid, 1'b1);
      chk($sformatf("E_hold_row%0d", i), out_row, out_fill(4, 4));
      chk($sformatf("E_hold_last%0d", i), out_last, 1'b0);
      chk($sformatf("E_hold_rdy%0d", i), in_ready, (i < 4));
      tick();
    end
    in_valid  = 1'b0;
    in_row    = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("E_pop_row%0d", k), out_row, (k == 0) ? out_fill(4, 4) : '0);
      chk($sformatf("E_pop_last%0d", k), out_last, (k == 3));
      chk($sformatf("E_pop_rdy%0d", k), in_ready, 1'b0);
      tick();
    end
    chk("E_nobubble_vld", out_valid, 1'b1);
    chk("E_nobubble_rdy", in_ready, 1'b1);
    clear_tables();
    exp_rows[0] = out_fill(12, 4);
    drain(4, 1'b1, 2'd0, "E2");

    // Reset during drain row 2 with a partial input block pending
    clear_tables();
    for (int r = 0; r < 4; r++) blk[r] = in_fill(1, 4);
    feed(4, 2'd0, 1'b0, "F");
    tick();
    in_valid = 1'b1;
    in_row   = in_fill(5, 8);
    size_i   = 2'd1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("F_at_row2_vld", out_valid, 1'b1);
    chk("F_at_row2_last", out_last, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("F_rst_in_ready", in_ready, 1'b1);
    chk("F_rst_out_valid", out_valid, 1'b0);
    chk("F_rst_out_last", out_last, 1'b0);
    chk("F_rst_out_row", out_row, '0);
    chk("F_rst_out_size", out_size, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Next block: N=8 from row 0, size_i toggled afterwards; impulse at in[7][0]
    clear_tables();
    blk[7] = in_fill(1, 1);
    exp_rows[0] = out_fill(1, 1);
    exp_rows[1] = out_fill(-1, 1);
    exp_rows[2] = out_fill(-1, 1);
    exp_rows[3] = out_fill(1, 1);
    exp_rows[4] = out_fill(-1, 1);
    exp_rows[5] = out_fill(1, 1);
    exp_rows[6] = out_fill(1, 1);
    exp_rows[7] = out_fill(-1, 1);
    feed(8, 2'd1, 1'b1, "G");
    tick();
    drain(8, 1'b1, 2'd1, "G");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
